// File: rtl/sap2_prog_loader.sv
// Host-driven program loader for the SAP-2: freezes the CPU, streams bytes into memory
// over a 4-phase handshake, then restarts the CPU. Transparent memory pass-through otherwise.
module sap2_prog_loader #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic              ld_strobe,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ack,
    output logic              ld_busy,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_idle,
    output logic              cpu_hold,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [15:0]       byte_count
);

    localparam int ADDR_BYTES = (ADDR_W <= 8) ? 1 : 2;
    localparam int RCNT_W     = $clog2(RST_CYCLES + 1);

    typedef enum logic [2:0] {
        S_RUN, S_HOLD, S_ADDR, S_DATA, S_WRITE, S_ACK_WAIT, S_RELEASE
    } state_t;

    state_t              r_state;
    state_t              r_next;
    logic                r_idx;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_count;
    logic                r_ack;
    logic                r_hold;
    logic                r_rst;
    logic [RCNT_W-1:0]   r_rcnt;
    logic [1:0]          r_en_sync;
    logic [1:0]          r_stb_sync;

    logic                w_en_s;
    logic                w_stb_s;
    logic                w_loader;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_ptr_load;

    assign w_en_s   = r_en_sync[1];
    assign w_stb_s  = r_stb_sync[1];
    assign w_loader = (r_state != S_RUN) && (r_state != S_HOLD);
    // Losing ld_en wins over a pending strobe; WRITE is not in this set so it always completes.
    assign w_abort  = !w_en_s &&
                      (r_state == S_ADDR || r_state == S_DATA || r_state == S_ACK_WAIT);

    // Replace one address byte of the pointer, high byte first for two-byte addresses.
    always_comb begin
        w_ptr_load = r_ptr;
        if (r_idx)
            w_ptr_load = (r_ptr & ADDR_W'(16'h00FF)) | ADDR_W'({ld_data, 8'h00});
        else
            w_ptr_load = (r_ptr & ~ADDR_W'(16'h00FF)) | ADDR_W'(ld_data);
    end

    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        if (w_loader) begin
            mem_addr  = r_ptr;
            mem_wdata = r_data;
            mem_we    = (r_state == S_WRITE);
        end
    end

    assign ld_ack     = r_ack;
    assign ld_busy    = (r_state != S_RUN);
    assign cpu_hold   = r_hold;
    assign cpu_rst    = r_rst;
    assign byte_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_sync  <= '0;
            r_stb_sync <= '0;
        end else begin
            // NOTE: non-blocking so each stage samples the previous stage's pre-edge value.
            r_en_sync  <= {r_en_sync[0], ld_en};
            r_stb_sync <= {r_stb_sync[0], ld_strobe};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_next  <= S_ADDR;
            r_idx   <= 1'b0;
            r_ptr   <= '0;
            r_data  <= '0;
            r_count <= '0;
            r_ack   <= 1'b0;
            r_hold  <= 1'b0;
            r_rst   <= 1'b0;
            r_rcnt  <= '0;
        end else if (w_abort) begin
            r_state <= S_RELEASE;
            r_ack   <= 1'b0;
            r_rst   <= 1'b1;
            r_rcnt  <= '0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_en_s) begin
                        r_state <= S_HOLD;
                        r_hold  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_en_s) begin
                        r_state <= S_RUN;
                        r_hold  <= 1'b0;
                    end else if (cpu_idle) begin
                        r_state <= S_ADDR;
                        r_idx   <= (ADDR_BYTES == 2);
                        r_count <= '0;
                    end
                end
                S_ADDR: begin
                    if (w_stb_s) begin
                        r_ptr   <= w_ptr_load;
                        r_ack   <= 1'b1;
                        r_state <= S_ACK_WAIT;
                        r_next  <= r_idx ? S_ADDR : S_DATA;
                        r_idx   <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (w_stb_s) begin
                        r_data  <= ld_data;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_ptr   <= r_ptr + ADDR_W'(1);
                    if (r_count != 16'hFFFF)
                        r_count <= r_count + 16'd1;
                    r_ack   <= 1'b1;
                    r_next  <= S_DATA;
                    r_state <= S_ACK_WAIT;
                end
                S_ACK_WAIT: begin
                    if (!w_stb_s) begin
                        r_ack   <= 1'b0;
                        r_state <= r_next;
                    end
                end
                S_RELEASE: begin
                    if (r_rcnt == RCNT_W'(RST_CYCLES - 1)) begin
                        r_state <= S_RUN;
                        r_hold  <= 1'b0;
                        r_rst   <= 1'b0;
                    end else begin
                        r_rcnt  <= r_rcnt + RCNT_W'(1);
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_sap2_prog_loader.sv
// Self-checking bench for sap2_prog_loader: 8-bit and 16-bit address instances, directed
// scenarios plus random load sessions scored against an expected write list.
module tb_sap2_prog_loader;

    localparam int RST_CYCLES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ld_en = 1'b0, ld_strobe = 1'b0, sel16 = 1'b0;
    logic [7:0]  ld_data = 8'h00;
    logic [15:0] cpu_addr = 16'h0000;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0, cpu_idle = 1'b0;

    logic        en8, stb8, en16, stb16;
    logic        ack8, busy8, hold8, rst8, mwe8;
    logic        ack16, busy16, hold16, rst16, mwe16;
    logic [7:0]  maddr8, mwd8, mwd16;
    logic [15:0] maddr16, bc8, bc16;

    assign en8   = ld_en & ~sel16;
    assign stb8  = ld_strobe & ~sel16;
    assign en16  = ld_en & sel16;
    assign stb16 = ld_strobe & sel16;

    logic        ack_m, busy_m, hold_m, rst_m;
    logic [15:0] bc_m;
    assign ack_m  = sel16 ? ack16  : ack8;
    assign busy_m = sel16 ? busy16 : busy8;
    assign hold_m = sel16 ? hold16 : hold8;
    assign rst_m  = sel16 ? rst16  : rst8;
    assign bc_m   = sel16 ? bc16   : bc8;

    sap2_prog_loader #(.ADDR_W(8), .DATA_W(8), .RST_CYCLES(RST_CYCLES)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .ld_en(en8), .ld_strobe(stb8), .ld_data(ld_data),
        .ld_ack(ack8), .ld_busy(busy8), .cpu_addr(cpu_addr[7:0]), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_idle(cpu_idle), .cpu_hold(hold8), .cpu_rst(rst8),
        .mem_addr(maddr8), .mem_wdata(mwd8), .mem_we(mwe8), .byte_count(bc8)
    );

    sap2_prog_loader #(.ADDR_W(16), .DATA_W(8), .RST_CYCLES(RST_CYCLES)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ld_en(en16), .ld_strobe(stb16), .ld_data(ld_data),
        .ld_ack(ack16), .ld_busy(busy16), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_we(cpu_we), .cpu_idle(cpu_idle), .cpu_hold(hold16), .cpu_rst(rst16),
        .mem_addr(maddr16), .mem_wdata(mwd16), .mem_we(mwe16), .byte_count(bc16)
    );

    // Observed memory writes as {addr[15:0], data[7:0]}.
    logic [23:0] wr_q[$];
    always @(negedge clk) begin
        if (mwe8)  wr_q.push_back({8'h00, maddr8, mwd8});
        if (mwe16) wr_q.push_back({maddr16, mwd16});
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] bytes_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input string tag);
        int n = 0;
        while (ack_m !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, ack_m}, {31'd0, val});
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_data   = b;
        ld_strobe = 1'b1;
        wait_ack(1'b1, "ack_rise");
        ld_strobe = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    // Called right after ld_en drops: expects a RST_CYCLES-long cpu_rst pulse under hold.
    task automatic check_release(input string tag);
        int n = 0;
        int hi = 0;
        while (rst_m !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rst_seen"}, {31'd0, rst_m}, 32'd1);
        check({tag, "_hold_in_rst"}, {31'd0, hold_m}, 32'd1);
        check({tag, "_ack_in_rst"}, {31'd0, ack_m}, 32'd0);
        while (rst_m === 1'b1 && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        check({tag, "_rst_len"}, hi, RST_CYCLES);
        check({tag, "_hold_after"}, {31'd0, hold_m}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy_m}, 32'd0);
    endtask

    // Full session: address bytes from start, then every byte in bytes_q, then ld_en drop.
    task automatic load_session(input logic is16, input logic [15:0] start, input string tag);
        logic [23:0] exp_q[$];
        logic [15:0] a;
        sel16    = is16;
        cpu_idle = 1'b1;
        wr_q.delete();
        ld_en    = 1'b1;
        if (is16) send_byte(start[15:8]);
        send_byte(start[7:0]);
        foreach (bytes_q[i]) begin
            a = start + 16'(i);
            if (!is16) a[15:8] = 8'h00;
            exp_q.push_back({a, bytes_q[i]});
            send_byte(bytes_q[i]);
        end
        ld_en = 1'b0;
        check_release(tag);
        check({tag, "_nwr"}, wr_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < wr_q.size()) check({tag, "_wr"}, {8'd0, wr_q[i]}, {8'd0, exp_q[i]});
        check({tag, "_count"}, {16'd0, bc_m}, bytes_q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_hi;
        logic        r16;
        logic [15:0] st;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, ack8}, 32'd0);
        check("rst_hold", {31'd0, hold8}, 32'd0);
        check("rst_cpu_rst", {31'd0, rst8}, 32'd0);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_count", {16'd0, bc8}, 32'd0);
        check("rst_mem_we", {31'd0, mwe8}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Pass-through in RUN
        cpu_addr = 16'h0012; cpu_wdata = 8'hA5; cpu_we = 1'b1;
        #1;
        check("pt_addr", {24'd0, maddr8}, 32'h12);
        check("pt_wdata", {24'd0, mwd8}, 32'hA5);
        check("pt_we", {31'd0, mwe8}, 32'd1);
        check("pt_hold", {31'd0, hold8}, 32'd0);
        check("pt_busy", {31'd0, busy8}, 32'd0);
        @(negedge clk);
        cpu_we = 1'b0;

        // Basic load
        bytes_q = '{8'h3E, 8'h7F, 8'h76};
        load_session(1'b0, 16'h0010, "basic");

        // Idle wait with strobe already high
        @(negedge clk);
        sel16 = 1'b0; wr_q.delete();
        cpu_idle = 1'b0; ld_data = 8'h40; ld_strobe = 1'b1; ld_en = 1'b1;
        for (int n = 0; n < 20 && busy8 !== 1'b1; n++) @(negedge clk);
        check("idle_busy", {31'd0, busy8}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold", {31'd0, hold8}, 32'd1);
            check("idle_ack", {31'd0, ack8}, 32'd0);
        end
        cpu_idle = 1'b1;
        wait_ack(1'b1, "idle_ack_rise");
        ld_strobe = 1'b0;
        wait_ack(1'b0, "idle_ack_fall");
        send_byte(8'h5A);
        ld_en = 1'b0;
        check_release("idle");
        check("idle_nwr", wr_q.size(), 32'd1);
        if (wr_q.size() > 0) check("idle_wr", {8'd0, wr_q[0]}, 32'h00405A);

        // Address wrap
        bytes_q = '{};
        for (int i = 0; i < 3; i++) bytes_q.push_back(8'($urandom));
        load_session(1'b0, 16'h00FE, "wrap");

        // 16-bit address
        bytes_q = '{8'hAB};
        load_session(1'b1, 16'h1234, "a16");

        // Random sessions
        for (int k = 0; k < 6; k++) begin
            r16 = 1'($urandom_range(0, 1));
            st  = 16'($urandom);
            if (!r16) st[15:8] = 8'h00;
            bytes_q = '{};
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) bytes_q.push_back(8'($urandom));
            load_session(r16, st, "rand");
        end

        // Abort in DATA while strobe rises in the same cycle
        @(negedge clk);
        sel16 = 1'b0; cpu_idle = 1'b1; wr_q.delete();
        ld_en = 1'b1;
        send_byte(8'h20);
        ld_data = 8'h99; ld_strobe = 1'b1; ld_en = 1'b0;
        check_release("abort");
        check("abort_nwr", wr_q.size(), 32'd0);
        check("abort_count", {16'd0, bc8}, 32'd0);
        check("abort_ack", {31'd0, ack8}, 32'd0);
        ld_strobe = 1'b0;
        repeat (4) @(negedge clk);

        // Asynchronous reset in ACK_WAIT
        ld_en = 1'b1;
        send_byte(8'h30);
        ld_data = 8'h11; ld_strobe = 1'b1;
        wait_ack(1'b1, "ares_ack");
        #2;
        rst_n = 1'b0;
        #1;
        check("ares_ack0", {31'd0, ack8}, 32'd0);
        check("ares_hold", {31'd0, hold8}, 32'd0);
        check("ares_cpu_rst", {31'd0, rst8}, 32'd0);
        check("ares_busy", {31'd0, busy8}, 32'd0);
        check("ares_count", {16'd0, bc8}, 32'd0);
        check("ares_mem_we", {31'd0, mwe8}, 32'd0);
        ld_en = 1'b0; ld_strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rst_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rst8 !== 1'b0) rst_hi++;
        end
        check("ares_no_pulse", rst_hi, 32'd0);
        check("ares_busy_after", {31'd0, busy8}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
